// File: rtl/data_sram_resp_if.sv
// Request/response bundle between the EX-stage initiator and the data SRAM.
// The initiator drives the request side; the SRAM returns data, valid and stall.
interface data_sram_resp_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        data_sram_rvalid;
    logic        stallreq_for_mem;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata,
        input  data_sram_rvalid,
        input  stallreq_for_mem
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata,
        output data_sram_rvalid,
        output stallreq_for_mem
    );
endinterface

// File: rtl/data_sram_resp.sv
// Word-addressed data SRAM: byte-lane writes in one cycle, reads answered with a
// one-cycle rvalid pulse READ_LAT cycles after accept while the pipeline is held.
//
// state | meaning
// IDLE  | accepting requests; writes commit at the edge, reads latch the index
// WAIT  | read in flight, cnt counts the remaining wait cycles down to 0
// RESP  | rvalid/rdata presented for one cycle, all requests ignored
module data_sram_resp #(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 2
) (
    input logic             clk,
    input logic             resetn,
    data_sram_resp_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_CNT = (READ_LAT > 1) ? 4'(READ_LAT - 2) : 4'd0;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_idx;
    logic [31:0]       r_rdata;
    logic              r_rvalid;
    logic [31:0]       r_mem [2**ADDR_W];

    logic [ADDR_W-1:0] w_idx;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_unused;

    // Byte offset and high address bits are dropped, so larger addresses alias.
    assign w_idx    = bus.data_sram_addr[ADDR_W+1:2];
    assign w_unused = ^{bus.data_sram_addr[31:ADDR_W+2], bus.data_sram_addr[1:0]};

    assign w_rd_acc = (r_state == IDLE) && bus.data_sram_en && (bus.data_sram_wen == 4'b0000);
    assign w_wr_acc = (r_state == IDLE) && bus.data_sram_en && (bus.data_sram_wen != 4'b0000);

    assign bus.stallreq_for_mem = w_rd_acc || (r_state == WAIT);
    assign bus.data_sram_rdata  = r_rdata;
    assign bus.data_sram_rvalid = r_rvalid;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_sram_wen[i]) begin
                    r_mem[w_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_idx    <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rd_acc) begin
                        r_idx <= w_idx;
                        if (READ_LAT == 1) begin
                            r_state  <= RESP;
                            r_rvalid <= 1'b1;
                            r_rdata  <= r_mem[w_idx];
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= LAT_CNT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state  <= RESP;
                        r_rvalid <= 1'b1;
                        r_rdata  <= r_mem[r_idx];
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
